// File: rtl/encoder_pwm_mixer_if.sv
// encoder_pwm_mixer_if: encoder inputs and level/PWM outputs shared by the mixer and its driver
interface encoder_pwm_mixer_if #(
  parameter int CHANNELS = 3,
  parameter int WIDTH = 8
);
  logic [CHANNELS-1:0] enc_a, enc_b, pwm_out;
  logic [CHANNELS*WIDTH-1:0] level;
  logic pwm_sync;
  modport master (output enc_a, enc_b, input pwm_out, level, pwm_sync);
  modport slave (input enc_a, enc_b, output pwm_out, level, pwm_sync);
endinterface

// File: rtl/encoder_pwm_mixer.sv
// encoder_pwm_mixer: debounced quadrature encoders set per-channel levels feeding shadowed PWM; define MIXER_SATURATE_EN to clamp levels instead of wrapping
module encoder_pwm_mixer #(
  parameter int CHANNELS = 3,
  parameter int WIDTH = 8,
  parameter int HIST_LEN = 8,
  parameter int STEP = 1
) (
  input logic clk,
  input logic reset_n,
  encoder_pwm_mixer_if.slave bus
);
  localparam int N = 2 * CHANNELS;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  logic [N-1:0] s1, s2, db;
  logic [CHANNELS-1:0] a_q, rise;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic wrap;
  assign cnt_nxt = cnt + 1'b1;
  assign wrap = cnt == MAX;
  assign rise = db[CHANNELS-1:0] & ~a_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      a_q <= '0;
      cnt <= '0;
      bus.pwm_sync <= 1'b0;
    end else begin
      s1 <= {bus.enc_b, bus.enc_a};
      s2 <= s1;
      a_q <= db[CHANNELS-1:0];
      cnt <= cnt_nxt;
      bus.pwm_sync <= wrap;
    end
  for (genvar j = 0; j < N; j++) begin : g_db
    logic [HIST_LEN-1:0] hist, hist_nxt;
    logic d;
    assign hist_nxt = {hist[HIST_LEN-2:0], s2[j]};
    assign db[j] = d;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        hist <= '0;
        d <= 1'b0;
      end else begin
        hist <= hist_nxt;
        d <= (hist_nxt == {HIST_LEN{~d}}) ? ~d : d;
      end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] lvl, sh, sh_nxt, up, dn;
    logic p;
`ifdef MIXER_SATURATE_EN
    assign up = (lvl > MAX - STEP_W) ? MAX : lvl + STEP_W;
    assign dn = (lvl < STEP_W) ? '0 : lvl - STEP_W;
`else
    assign up = lvl + STEP_W;
    assign dn = lvl - STEP_W;
`endif
    // duty is latched on the last count so the new value starts exactly with the period
    assign sh_nxt = wrap ? lvl : sh;
    assign bus.level[i*WIDTH +: WIDTH] = lvl;
    assign bus.pwm_out[i] = p;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        lvl <= '0;
        sh <= '0;
        p <= 1'b0;
      end else begin
        lvl <= rise[i] ? (db[CHANNELS+i] ? dn : up) : lvl;
        sh <= sh_nxt;
        p <= cnt_nxt < sh_nxt;
      end
  end
endmodule

// File: tb/tb_encoder_pwm_mixer.sv
// tb_encoder_pwm_mixer: directed checks of debounce, direction, simultaneity, shadowing, extremes and reset
module tb_encoder_pwm_mixer;
  logic clk = 1'b0;
  logic reset_n;
  int tests = 0;
  int fails = 0;
  int hi[3] = '{0, 0, 0};
  int last_hi[3] = '{0, 0, 0};
  logic [7:0] lv_m[3] = '{8'd0, 8'd0, 8'd0};
  encoder_pwm_mixer_if #(.CHANNELS(3), .WIDTH(8)) bus ();
  encoder_pwm_mixer dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
`ifdef MIXER_SATURATE_EN
  localparam logic [7:0] DIR_EXP = 8'd0;
  localparam logic [7:0] OVF_EXP = 8'd255;
`else
  localparam logic [7:0] DIR_EXP = 8'd251;
  localparam logic [7:0] OVF_EXP = 8'd0;
`endif
  function automatic logic [7:0] up(input logic [7:0] v);
`ifdef MIXER_SATURATE_EN
    return (v == 8'hFF) ? v : v + 8'd1;
`else
    return v + 8'd1;
`endif
  endfunction
  function automatic logic [7:0] dn(input logic [7:0] v);
`ifdef MIXER_SATURATE_EN
    return (v == 8'h00) ? v : v - 8'd1;
`else
    return v - 8'd1;
`endif
  endfunction
  function automatic logic [7:0] lvl(input int c);
    return bus.level[c*8 +: 8];
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      if (bus.pwm_sync) begin
        last_hi[c] = hi[c];
        hi[c] = 0;
      end
      hi[c] += int'(bus.pwm_out[c]);
    end
  endtask
  task automatic detent(input logic [2:0] m);
    bus.enc_a = bus.enc_a | m;
    repeat (12) tick();
    bus.enc_a = bus.enc_a & ~m;
    repeat (12) tick();
    for (int c = 0; c < 3; c++)
      if (m[c]) lv_m[c] = bus.enc_b[c] ? dn(lv_m[c]) : up(lv_m[c]);
  endtask
  task automatic wait_sync();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.pwm_sync && n < 300);
    check("sync_seen", 32'(bus.pwm_sync), 32'd1);
  endtask
  initial begin
    int syncs;
    reset_n = 1'b0;
    bus.enc_a = '0;
    bus.enc_b = '0;
    for (int k = 0; k < 20; k++) begin
      bus.enc_a = 3'($urandom);
      bus.enc_b = 3'($urandom);
      tick();
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_pwm", 32'(bus.pwm_out), 32'd0);
      check("rst_sync", 32'(bus.pwm_sync), 32'd0);
    end
    bus.enc_a = '0;
    bus.enc_b = '0;
    repeat (4) tick();
    reset_n = 1'b1;
    syncs = 0;
    for (int k = 0; k < 255; k++) begin
      tick();
      syncs += int'(bus.pwm_sync);
    end
    check("no_early_sync", 32'(syncs), 32'd0);
    tick();
    check("first_sync", 32'(bus.pwm_sync), 32'd1);
    tick();
    check("sync_one_cycle", 32'(bus.pwm_sync), 32'd0);
    for (int k = 0; k < 6; k++) begin
      bus.enc_a[0] = ~bus.enc_a[0];
      repeat (3) tick();
    end
    check("bounce_ignored", 32'(bus.level), 32'd0);
    bus.enc_a[0] = 1'b1;
    repeat (10) tick();
    check("bounce_lat10", 32'(lvl(0)), 32'd0);
    tick();
    check("bounce_lat11", 32'(lvl(0)), 32'd1);
    repeat (20) tick();
    check("bounce_once", 32'(lvl(0)), 32'd1);
    bus.enc_a[0] = 1'b0;
    repeat (12) tick();
    check("fall_no_effect", 32'(lvl(0)), 32'd1);
    lv_m[0] = 8'd1;
    bus.enc_b[1] = 1'b1;
    repeat (12) tick();
    check("b_edge_no_effect", 32'(lvl(1)), 32'd0);
    repeat (5) detent(3'b010);
    check("dir_down", 32'(lvl(1)), 32'(DIR_EXP));
    check("dir_ch0", 32'(lvl(0)), 32'd1);
    check("dir_ch2", 32'(lvl(2)), 32'd0);
    bus.enc_b[1] = 1'b0;
    repeat (12) tick();
    for (int k = 0; k < 300 && lv_m[1] != 8'd255; k++) detent(3'b010);
    check("up_to_max", 32'(lvl(1)), 32'd255);
    wait_sync();
    wait_sync();
    check("pwm_max", 32'(last_hi[1]), 32'd255);
    check("pwm_zero", 32'(last_hi[2]), 32'd0);
    check("pwm_one", 32'(last_hi[0]), 32'd1);
    detent(3'b010);
    check("overflow", 32'(lvl(1)), 32'(OVF_EXP));
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_level", 32'(bus.level), 32'd0);
    check("async_pwm", 32'(bus.pwm_out), 32'd0);
    check("async_sync", 32'(bus.pwm_sync), 32'd0);
    repeat (3) tick();
    lv_m = '{8'd0, 8'd0, 8'd0};
    hi = '{0, 0, 0};
    reset_n = 1'b1;
    repeat (10) detent(3'b111);
    check("sim_ten", 32'(bus.level), 32'h0A0A0A);
    bus.enc_b = 3'b010;
    repeat (12) tick();
    bus.enc_a = 3'b111;
    repeat (10) tick();
    check("sim_before", 32'(bus.level), 32'h0A0A0A);
    tick();
    check("sim_same_cycle", 32'(bus.level), 32'h0B090B);
    lv_m = '{8'd11, 8'd9, 8'd11};
    bus.enc_a = 3'b000;
    repeat (12) tick();
    bus.enc_b = 3'b000;
    repeat (12) tick();
    check("sim_hold", 32'(bus.level), 32'h0B090B);
    for (int k = 0; k < 60 && lv_m[0] != 8'd63; k++) detent(3'b001);
    check("climb_63", 32'(lvl(0)), 32'd63);
    wait_sync();
    wait_sync();
    check("pwm_63", 32'(last_hi[0]), 32'd63);
    bus.enc_a[0] = 1'b1;
    repeat (12) tick();
    check("level_64", 32'(lvl(0)), 32'd64);
    bus.enc_a[0] = 1'b0;
    wait_sync();
    check("shadow_hold", 32'(last_hi[0]), 32'd63);
    wait_sync();
    check("shadow_new", 32'(last_hi[0]), 32'd64);
    check("pwm_ch1_9", 32'(last_hi[1]), 32'd9);
    check("pwm_ch2_11", 32'(last_hi[2]), 32'd11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/encoder_pwm_mixer.md
ENCODER_PWM_MIXER -- requirements
Module: encoder_pwm_mixer

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent encoder/PWM channels, 1..8.
REQ-002 Parameter WIDTH, default 8: width of each level register and of the PWM counter, 4..12.
REQ-003 Parameter HIST_LEN, default 8: debounce history length in samples, 2..16.
REQ-004 Parameter STEP, default 1: level change per encoder detent, 1..2^(WIDTH-1).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 enc_a  input  CHANNELS  quadrature A per channel; bit i belongs to channel i; asynchronous, bouncy.
REQ-008 enc_b  input  CHANNELS  quadrature B per channel; bit i belongs to channel i; asynchronous, bouncy.
REQ-009 pwm_out  output  CHANNELS  PWM output per channel; registered.
REQ-010 level  output  CHANNELS*WIDTH  current level; channel i at bits [i*WIDTH +: WIDTH]; registered.
REQ-011 pwm_sync  output  1  one-cycle pulse at the start of every PWM period.

Function
REQ-012 Each enc_a/enc_b bit shall pass through a 2-flop synchroniser, then a debouncer with its own HIST_LEN-bit shift history.
REQ-013 Each debounced output shall change only when all HIST_LEN history bits equal the opposite of its current value; debounce latency is 2 + HIST_LEN cycles after a stable input change.
REQ-014 On a debounced A rising edge: level += STEP if debounced B = 0, level -= STEP if debounced B = 1; A falling edges and B edges shall have no effect.
REQ-015 Channels shall be fully independent; simultaneous events on several channels in one cycle shall all be applied.
REQ-016 level shall update one cycle after the debounced A rising edge.
REQ-017 Arithmetic overflow/underflow: behaviour per REQ-026/REQ-027.
REQ-018 A single shared WIDTH-bit PWM counter shall count 0..2^WIDTH-1 and wrap to 0.
REQ-019 Each channel shall hold a shadow duty register loaded from its level when the counter equals 2^WIDTH-1, so new levels take effect only at period start (glitch-free).
REQ-020 pwm_out[i] shall be 1 exactly when counter < shadow[i]; shadow 0 gives constant 0; shadow 2^WIDTH-1 gives high for all but one cycle per period.
REQ-021 pwm_sync shall be 1 in exactly the cycle in which the counter equals 0.

Reset
REQ-022 While reset_n = 0: all level registers, shadow registers, PWM counter, synchroniser flops, histories and debounced values shall be 0.
REQ-023 While reset_n = 0: pwm_out = 0 and pwm_sync = 0.
REQ-024 Reset assertion mid-period shall clear state immediately, without waiting for a clock edge.
REQ-025 After reset_n rises, the counter shall start at 0 on the first clock edge; that cycle's pwm_sync shall be 0; the next sync pulse shall occur at the following wrap.

Configuration
REQ-026 With MIXER_SATURATE_EN defined: increments shall clamp at 2^WIDTH-1 and decrements at 0 (e.g. WIDTH=8, STEP=4, level 253 + detent gives 255).
REQ-027 Without MIXER_SATURATE_EN: level arithmetic shall wrap modulo 2^WIDTH (255 + 1 gives 0; 0 - 1 gives 255).

Verification
REQ-028 Reset: hold reset_n = 0 with enc inputs toggling -> level = 0, pwm_out = 0 and pwm_sync = 0 throughout.
REQ-029 Bounce: channel 0 A toggles every 3 cycles for 20 cycles, then holds 1, B = 0 (HIST_LEN = 8) -> exactly one increment, level0 = 1, 11 cycles after A goes stable.
REQ-030 Direction: 5 clean detents on channel 1 with B = 1 from level 0 -> level1 = 0 (saturate build) or 251 (wrap build); channels 0 and 2 unchanged.
REQ-031 Simultaneous: detents on all 3 channels in the same cycle, B = 0/1/0, starting from 10 -> levels 11/9/11, all updated in the same cycle.
REQ-032 Shadowing: set level0 = 64 mid-period -> pwm_out[0] unchanged until the cycle after pwm_sync; then high for exactly 64 of 256 cycles.
REQ-033 Extremes: level 0 -> pwm_out stays 0; level 255 -> pwm_out high for 255 cycles, low for 1, per period.
